// File: rtl/lotr_pkg.sv
// Shared LOTR fabric definitions: reset sequencer state encoding and its
// default parameter values.
package lotr_pkg;

    typedef enum logic [2:0] {
        RESET   = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        END     = 3'd4
    } t_rst_seq_state;

    localparam int unsigned LOTR_RST_NUM_CORES   = 4;
    localparam int unsigned LOTR_RST_HOLD_CYCLES = 8;
    localparam int unsigned LOTR_RST_STAGGER     = 2;
    localparam int unsigned LOTR_RST_TIMEOUT     = 1000;
    localparam int unsigned LOTR_RST_CNT_W       = 16;

endpackage

// File: rtl/lotr_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the
// second clk edge after rst_n rises.
//   clk        : destination clock
//   rst_n      : raw asynchronous active-low reset
//   rst_sync_n : synchronised active-low reset
module lotr_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_sync_n <= meta;
        end
    end

endmodule

// File: rtl/lotr_rst_seq.sv
// Reset sequencer and run watchdog for the LOTR core array. Holds all cores
// in reset for HOLD_CYCLES, releases them STAGGER cycles apart, then watches
// for all-done or a cycle timeout and reports sticky status.
//   QClk          : clock
//   RstQnnnL      : asynchronous active-low reset
//   SwRstReqQnnnH : software re-sequence request (level)
//   CoreDoneQnnnH : per-core done
//   CoreRstQnnnH  : per-core reset (active-high)
//   RunQnnnH      : all cores released and running
//   DoneQnnnH     : sticky all-done
//   TimeoutQnnnH  : sticky watchdog expiry
//   StateQnnnH    : current sequencer state
module lotr_rst_seq
    import lotr_pkg::*;
#(
    parameter int unsigned NUM_CORES   = LOTR_RST_NUM_CORES,
    parameter int unsigned HOLD_CYCLES = LOTR_RST_HOLD_CYCLES,
    parameter int unsigned STAGGER     = LOTR_RST_STAGGER,
    parameter int unsigned TIMEOUT     = LOTR_RST_TIMEOUT,
    parameter int unsigned CNT_W       = LOTR_RST_CNT_W
) (
    input  logic                 QClk,
    input  logic                 RstQnnnL,
    input  logic                 SwRstReqQnnnH,
    input  logic [NUM_CORES-1:0] CoreDoneQnnnH,
    output logic [NUM_CORES-1:0] CoreRstQnnnH,
    output logic                 RunQnnnH,
    output logic                 DoneQnnnH,
    output logic                 TimeoutQnnnH,
    output logic [2:0]           StateQnnnH
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(STAGGER * (NUM_CORES - 1));
    localparam bit               WDOG_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST    = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               DIRECT_RUN = (STAGGER == 0) || (NUM_CORES == 1);

    logic                 rst_sync_n;
    t_rst_seq_state       state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc_c;
    logic [NUM_CORES-1:0] rel_rst_c;
    logic                 all_done_c;

    lotr_rst_sync u_sync (
        .clk        (QClk),
        .rst_n      (RstQnnnL),
        .rst_sync_n (rst_sync_n)
    );

    // Shared phase counter increments without wrapping.
    assign cnt_inc_c  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign all_done_c = &CoreDoneQnnnH;
    assign StateQnnnH = state;

    // Core i stays in reset until the phase count reaches STAGGER*i.
    always_comb begin
        rel_rst_c = '1;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            rel_rst_c[i] = (cnt_inc_c < CNT_W'(STAGGER * unsigned'(i)));
        end
    end

    // Sequencer FSM with registered outputs; software request overrides all.
    always_ff @(posedge QClk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= RESET;
            cnt          <= '0;
            CoreRstQnnnH <= '1;
            RunQnnnH     <= 1'b0;
            DoneQnnnH    <= 1'b0;
            TimeoutQnnnH <= 1'b0;
        end else if (SwRstReqQnnnH) begin
            state        <= RESET;
            cnt          <= '0;
            CoreRstQnnnH <= '1;
            RunQnnnH     <= 1'b0;
            DoneQnnnH    <= 1'b0;
            TimeoutQnnnH <= 1'b0;
        end else begin
            case (state)
                RESET: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (DIRECT_RUN) begin
                            state        <= RUN;
                            CoreRstQnnnH <= '0;
                            RunQnnnH     <= 1'b1;
                        end else begin
                            state        <= RELEASE;
                            CoreRstQnnnH <= ~NUM_CORES'(1);
                        end
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                RELEASE: begin
                    if (cnt_inc_c >= REL_LAST) begin
                        state        <= RUN;
                        cnt          <= '0;
                        CoreRstQnnnH <= '0;
                        RunQnnnH     <= 1'b1;
                    end else begin
                        cnt          <= cnt_inc_c;
                        CoreRstQnnnH <= rel_rst_c;
                    end
                end
                RUN: begin
                    // Done takes precedence over a coincident timeout.
                    if (all_done_c) begin
                        state        <= END;
                        CoreRstQnnnH <= '1;
                        RunQnnnH     <= 1'b0;
                        DoneQnnnH    <= 1'b1;
                    end else if (WDOG_EN && (cnt == TO_LAST)) begin
                        state        <= END;
                        CoreRstQnnnH <= '1;
                        RunQnnnH     <= 1'b0;
                        TimeoutQnnnH <= 1'b1;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                END: begin
                    state <= END;
                end
                default: begin
                    state        <= RESET;
                    cnt          <= '0;
                    CoreRstQnnnH <= '1;
                    RunQnnnH     <= 1'b0;
                end
            endcase
        end
    end

endmodule
